// File: rtl/reg_pipe_stage.sv
`timescale 1ns/1ps
// reg_pipe_stage: one elastic register stage with valid/ready on both sides.
//   SKID = 0: single entry, upstream ready is combinational from downstream ready.
//   SKID = 1: main + skid entry, upstream ready is a register output.
// Ports:
//   clk, reset (async, active-low), flush (sync, discards the held word(s))
//   up_valid/up_ready/up_data       : upstream side
//   down_valid/down_ready/down_data : downstream side
module reg_pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter int               SKID      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_data
);

  if (SKID == 0) begin : g_plain
    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic             load;
    logic             drain;

    assign up_ready   = !valid_reg || down_ready;
    assign load       = up_valid && up_ready;
    assign drain      = valid_reg && down_ready;
    assign down_valid = valid_reg;
    assign down_data  = data_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_reg <= 1'b0;
        data_reg  <= RESET_VAL;
      end else begin
        if (flush)      valid_reg <= 1'b0;
        else if (load)  valid_reg <= 1'b1;
        else if (drain) valid_reg <= 1'b0;
        // Data only moves on a real load; an emptied stage keeps its last word.
        if (load && !flush) data_reg <= up_data;
      end
    end
  end else begin : g_skid
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] main_reg, main_next;
    logic [WIDTH-1:0] skid_reg, skid_next;
    logic             ready_reg;
    logic             load;
    logic             drain;

    assign up_ready   = ready_reg;
    assign down_valid = (state_reg != ST_EMPTY);
    assign down_data  = main_reg;
    assign load       = up_valid && ready_reg;
    assign drain      = down_valid && down_ready;

    always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
        ST_EMPTY: begin
          if (load) begin
            state_next = ST_HALF;
            main_next  = up_data;
          end
        end
        ST_HALF: begin
          if (load && drain) begin
            main_next = up_data;
          end else if (load) begin
            state_next = ST_FULL;
            skid_next  = up_data;
          end else if (drain) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Oldest word leaves from main; the skid word takes its place.
          if (drain) begin
            state_next = ST_HALF;
            main_next  = skid_reg;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
      if (flush) begin
        state_next = ST_EMPTY;
        main_next  = main_reg;
        skid_next  = skid_reg;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg <= ST_EMPTY;
        main_reg  <= RESET_VAL;
        skid_reg  <= RESET_VAL;
        // Held low during reset, rises on the first edge after release.
        ready_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        main_reg  <= main_next;
        skid_reg  <= skid_next;
        ready_reg <= (state_next != ST_FULL);
      end
    end
  end

endmodule

// File: rtl/reg_pipe.sv
`timescale 1ns/1ps
// reg_pipe: elastic pipeline of DEPTH reg_pipe_stage instances with valid/ready
// handshake, synchronous flush and a registered occupancy count.
// Ports:
//   clk, reset (async, active-low), flush (sync)
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side
//   occupancy                    : words held, 0..CAP with CAP = DEPTH*(1+SKID)
module reg_pipe #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter int               SKID      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CAP       = DEPTH * (1 + SKID),
  localparam int              OCC_W     = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] up_data;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] down_data;

    if (gi == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_link
      assign up_valid = g_stage[gi-1].down_valid;
      assign up_data  = g_stage[gi-1].down_data;
    end

    if (gi == DEPTH - 1) begin : g_last
      assign down_ready = out_ready;
    end else begin : g_next
      assign down_ready = g_stage[gi+1].up_ready;
    end

    reg_pipe_stage #(
      .WIDTH     (WIDTH),
      .SKID      (SKID),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_data    (up_data),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_data  (down_data)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[DEPTH-1].down_valid;
  assign out_data  = g_stage[DEPTH-1].down_data;

  logic [OCC_W-1:0] occ_reg, occ_next;
  logic             push;
  logic             pop;

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = occ_reg;

  always_comb begin
    occ_next = occ_reg;
    if (flush)              occ_next = '0;
    else if (push && !pop)  occ_next = occ_reg + 1'b1;
    else if (pop && !push)  occ_next = occ_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_reg <= '0;
    else        occ_reg <= occ_next;
  end

endmodule

// File: tb/tb_reg_pipe.sv
`timescale 1ns/1ps
// tb_reg_pipe: drives two reg_pipe instances (DEPTH = 4), SKID = 0 with
// RESET_VAL = 0 and SKID = 1 with RESET_VAL = 0xDEAD_BEEF, side by side with
// independent stimulus and directed expectations.
module tb_reg_pipe;
  localparam int DEPTH = 4;
  localparam int NDUT  = 2;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid  [NDUT];
  logic [31:0] in_data   [NDUT];
  logic        out_ready [NDUT];
  wire         in_ready  [NDUT];
  wire         out_valid [NDUT];
  wire  [31:0] out_data  [NDUT];
  wire  [7:0]  occ       [NDUT];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  for (gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int CAP_G = DEPTH * (1 + gi);
    wire [$clog2(CAP_G+1)-1:0] occ_w;
    reg_pipe #(
      .WIDTH     (32),
      .DEPTH     (DEPTH),
      .SKID      (gi),
      .RESET_VAL ((gi == 1) ? 32'hDEAD_BEEF : 32'h0000_0000)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid[gi]),
      .in_ready  (in_ready[gi]),
      .in_data   (in_data[gi]),
      .out_valid (out_valid[gi]),
      .out_ready (out_ready[gi]),
      .out_data  (out_data[gi]),
      .occupancy (occ_w)
    );
    assign occ[gi] = 8'(occ_w);
  end

  function automatic logic [31:0] rv_of(input int d);
    return (d == 1) ? 32'hDEAD_BEEF : 32'h0000_0000;
  endfunction

  function automatic int cap_of(input int d);
    return DEPTH * (1 + d);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    flush = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      in_valid[d] = 1'b0; in_data[d] = 32'h0; out_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL reset_out_valid dut%0d got=%0b want=0", d, out_valid[d]); end
      total++; if (occ[d] !== 8'd0) begin bad++; $display("FAIL reset_occ dut%0d got=%0d want=0", d, occ[d]); end
      total++; if (out_data[d] !== rv_of(d)) begin bad++; $display("FAIL reset_out_data dut%0d got=%h want=%h", d, out_data[d], rv_of(d)); end
      total++; if (in_ready[d] !== (d == 0)) begin bad++; $display("FAIL reset_in_ready dut%0d got=%0b want=%0b", d, in_ready[d], d == 0); end
    end
    reset = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      total++; if (in_ready[d] !== (d == 0)) begin bad++; $display("FAIL release_in_ready dut%0d got=%0b want=%0b", d, in_ready[d], d == 0); end
    end
    tick();
    for (int d = 0; d < NDUT; d++) begin
      total++; if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL first_edge_in_ready dut%0d got=%0b want=1", d, in_ready[d]); end
      total++; if (out_data[d] !== rv_of(d)) begin bad++; $display("FAIL idle_out_data dut%0d got=%h want=%h", d, out_data[d], rv_of(d)); end
    end
    $display("test_reset done: total=%0d", total);
  endtask

  task automatic test_stream;
    for (int c = 0; c <= 63 + DEPTH; c++) begin
      int acc, dlv;
      logic exp_v;
      for (int d = 0; d < NDUT; d++) begin
        in_valid[d]  = (c < 63);
        in_data[d]   = (c < 63) ? 32'(c + 1) : 32'h0;
        out_ready[d] = 1'b1;
      end
      @(negedge clk);
      acc = (c < 63) ? c : 63;
      dlv = (c - DEPTH < 0) ? 0 : ((c - DEPTH > 63) ? 63 : c - DEPTH);
      exp_v = (c >= DEPTH) && (c < 63 + DEPTH);
      for (int d = 0; d < NDUT; d++) begin
        if (c < 63) begin
          total++; if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL stream_in_ready dut%0d c=%0d got=%0b want=1", d, c, in_ready[d]); end
        end
        total++; if (out_valid[d] !== exp_v) begin bad++; $display("FAIL stream_out_valid dut%0d c=%0d got=%0b want=%0b", d, c, out_valid[d], exp_v); end
        if (exp_v) begin
          total++; if (out_data[d] !== 32'(c - DEPTH + 1)) begin bad++; $display("FAIL stream_out_data dut%0d c=%0d got=%h want=%h", d, c, out_data[d], 32'(c - DEPTH + 1)); end
        end else if (c < DEPTH) begin
          total++; if (out_data[d] !== rv_of(d)) begin bad++; $display("FAIL stream_reset_val dut%0d c=%0d got=%h want=%h", d, c, out_data[d], rv_of(d)); end
        end
        total++; if (occ[d] !== 8'(acc - dlv)) begin bad++; $display("FAIL stream_occ dut%0d c=%0d got=%0d want=%0d", d, c, occ[d], acc - dlv); end
      end
      tick();
    end
    $display("test_stream done: total=%0d", total);
  endtask

  task automatic test_fill;
    logic [31:0] base;
    base = 32'hA5A5_0001;
    for (int k = 0; k < 20; k++) begin
      for (int d = 0; d < NDUT; d++) begin
        in_valid[d] = 1'b1; in_data[d] = base + 32'(k); out_ready[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        total++; if (in_ready[d] !== (k < cap_of(d))) begin bad++; $display("FAIL fill_in_ready dut%0d k=%0d got=%0b want=%0b", d, k, in_ready[d], k < cap_of(d)); end
        if (k >= DEPTH) begin
          total++; if (out_valid[d] !== 1'b1) begin bad++; $display("FAIL fill_out_valid dut%0d k=%0d got=%0b want=1", d, k, out_valid[d]); end
          total++; if (out_data[d] !== base) begin bad++; $display("FAIL fill_out_data dut%0d k=%0d got=%h want=%h", d, k, out_data[d], base); end
        end
      end
      tick();
    end
    for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (occ[d] !== 8'(cap_of(d))) begin bad++; $display("FAIL fill_occ dut%0d got=%0d want=%0d", d, occ[d], cap_of(d)); end
    end
    tick();
    for (int j = 0; j <= 2 * DEPTH; j++) begin
      for (int d = 0; d < NDUT; d++) out_ready[d] = 1'b1;
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        total++; if (out_valid[d] !== (j < cap_of(d))) begin bad++; $display("FAIL drain_out_valid dut%0d j=%0d got=%0b want=%0b", d, j, out_valid[d], j < cap_of(d)); end
        if (j < cap_of(d)) begin
          total++; if (out_data[d] !== base + 32'(j)) begin bad++; $display("FAIL drain_out_data dut%0d j=%0d got=%h want=%h", d, j, out_data[d], base + 32'(j)); end
        end
        total++; if (occ[d] !== 8'((j < cap_of(d)) ? cap_of(d) - j : 0)) begin bad++; $display("FAIL drain_occ dut%0d j=%0d got=%0d", d, j, occ[d]); end
      end
      tick();
    end
    $display("test_fill done: total=%0d", total);
  endtask

  task automatic test_flush;
    bit found [NDUT];
    for (int k = 0; k < 3; k++) begin
      for (int d = 0; d < NDUT; d++) begin
        in_valid[d] = 1'b1; in_data[d] = 32'h100 + 32'(k); out_ready[d] = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        total++; if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL flush_push_ready dut%0d k=%0d got=%0b want=1", d, k, in_ready[d]); end
      end
      tick();
    end
    flush = 1'b1;
    for (int d = 0; d < NDUT; d++) begin in_valid[d] = 1'b1; in_data[d] = 32'h77; end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (occ[d] !== 8'd3) begin bad++; $display("FAIL preflush_occ dut%0d got=%0d want=3", d, occ[d]); end
    end
    tick();
    flush = 1'b0;
    for (int d = 0; d < NDUT; d++) begin in_valid[d] = 1'b1; in_data[d] = 32'h42; out_ready[d] = 1'b1; end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (occ[d] !== 8'd0) begin bad++; $display("FAIL flush_occ dut%0d got=%0d want=0", d, occ[d]); end
      total++; if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL flush_out_valid dut%0d got=%0b want=0", d, out_valid[d]); end
      total++; if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL postflush_ready dut%0d got=%0b want=1", d, in_ready[d]); end
      found[d] = 1'b0;
    end
    tick();
    for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (!found[d] && out_valid[d]) begin
          found[d] = 1'b1;
          total++; if (out_data[d] !== 32'h42) begin bad++; $display("FAIL flush_first_word dut%0d got=%h want=00000042", d, out_data[d]); end
        end
      end
      tick();
    end
    for (int d = 0; d < NDUT; d++) begin
      total++; if (!found[d]) begin bad++; $display("FAIL flush_timeout dut%0d got=none want=00000042", d); end
      total++; if (occ[d] !== 8'd0 || out_valid[d] !== 1'b0) begin bad++; $display("FAIL flush_leftover dut%0d occ=%0d valid=%0b want=0/0", d, occ[d], out_valid[d]); end
    end
    $display("test_flush done: total=%0d", total);
  endtask

  task automatic test_reset_mid;
    bit found [NDUT];
    for (int k = 0; k < 2; k++) begin
      for (int d = 0; d < NDUT; d++) begin
        in_valid[d] = 1'b1; in_data[d] = 32'h200 + 32'(k); out_ready[d] = 1'b0;
      end
      tick();
    end
    for (int d = 0; d < NDUT; d++) in_data[d] = 32'h202;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (occ[d] !== 8'd2) begin bad++; $display("FAIL midrst_pre_occ dut%0d got=%0d want=2", d, occ[d]); end
    end
    #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      total++; if (out_valid[d] !== 1'b0) begin bad++; $display("FAIL midrst_out_valid dut%0d got=%0b want=0", d, out_valid[d]); end
      total++; if (out_data[d] !== rv_of(d)) begin bad++; $display("FAIL midrst_out_data dut%0d got=%h want=%h", d, out_data[d], rv_of(d)); end
      total++; if (occ[d] !== 8'd0) begin bad++; $display("FAIL midrst_occ dut%0d got=%0d want=0", d, occ[d]); end
      total++; if (in_ready[d] !== (d == 0)) begin bad++; $display("FAIL midrst_in_ready dut%0d got=%0b want=%0b", d, in_ready[d], d == 0); end
    end
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b0;
    tick();
    for (int d = 0; d < NDUT; d++) begin in_valid[d] = 1'b1; in_data[d] = 32'h55; out_ready[d] = 1'b1; found[d] = 1'b0; end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (in_ready[d] !== 1'b1) begin bad++; $display("FAIL midrst_restart_ready dut%0d got=%0b want=1", d, in_ready[d]); end
    end
    tick();
    for (int d = 0; d < NDUT; d++) in_valid[d] = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (!found[d] && out_valid[d]) begin
          found[d] = 1'b1;
          total++; if (out_data[d] !== 32'h55) begin bad++; $display("FAIL midrst_first_word dut%0d got=%h want=00000055", d, out_data[d]); end
        end
      end
      tick();
    end
    for (int d = 0; d < NDUT; d++) begin
      total++; if (!found[d]) begin bad++; $display("FAIL midrst_timeout dut%0d got=none want=00000055", d); end
      total++; if (occ[d] !== 8'd0 || out_valid[d] !== 1'b0) begin bad++; $display("FAIL midrst_leftover dut%0d occ=%0d valid=%0b want=0/0", d, occ[d], out_valid[d]); end
    end
    $display("test_reset_mid done: total=%0d", total);
  endtask

  task automatic test_random;
    logic [31:0] sb [NDUT][$];
    for (int cyc = 0; cyc < 4000 + 64; cyc++) begin
      bool_drive: begin
        for (int d = 0; d < NDUT; d++) begin
          if (cyc < 4000) begin
            in_valid[d]  = 1'($urandom_range(0, 1));
            out_ready[d] = 1'($urandom_range(0, 1));
            in_data[d]   = $urandom;
          end else begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
          end
        end
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        total++; if (occ[d] !== 8'(sb[d].size())) begin bad++; $display("FAIL rand_occ dut%0d cyc=%0d got=%0d want=%0d", d, cyc, occ[d], sb[d].size()); end
        if (d == 1) begin
          total++; if (in_ready[d] === 1'b1 && sb[d].size() == cap_of(d)) begin bad++; $display("FAIL rand_full_ready dut%0d cyc=%0d got=1 want=0", d, cyc); end
        end
        if (out_valid[d] && out_ready[d]) begin
          total++;
          if (sb[d].size() == 0) begin
            bad++; $display("FAIL rand_extra_word dut%0d cyc=%0d got=%h want=none", d, cyc, out_data[d]);
          end else begin
            logic [31:0] exp_w;
            exp_w = sb[d].pop_front();
            if (out_data[d] !== exp_w) begin bad++; $display("FAIL rand_data dut%0d cyc=%0d got=%h want=%h", d, cyc, out_data[d], exp_w); end
          end
        end
        if (in_valid[d] && in_ready[d]) sb[d].push_back(in_data[d]);
      end
      tick();
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      total++; if (sb[d].size() != 0 || occ[d] !== 8'd0) begin bad++; $display("FAIL rand_residual dut%0d left=%0d occ=%0d want=0/0", d, sb[d].size(), occ[d]); end
    end
    $display("test_random done: total=%0d", total);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
